polymem_arbiter: RTL and testbench
==================================

// Module: polymem_arbiter
// PURPOSE
//   Shares one 256x24 simple-dual-port coefficient RAM between two requesters:
//   requester 0 is the NTT core and requester 1 is the sampler/packer.
//   - The write port (RAM port A) and the read port (RAM port B) are arbitrated
//     independently, each round-robin.
//   - The block tracks the 1-cycle RAM read latency and returns read data to
//     the requester that issued the read.
//   - A built-in clear sequencer zero-fills the whole polynomial buffer.
// PARAMETERS
//   AW   8    RAM address width (depth = 2**AW = 256 coefficients)
//   DW   24   RAM data width
// PORTS
//   clk          in   1      single clock for the arbiter and both RAM ports
//   rst_n        in   1      asynchronous reset, active-low
//   wr_req       in   2      write request, one bit per requester
//   wr_addr0/1   in   AW     write address, requester 0/1
//   wr_data0/1   in   DW     write data, requester 0/1
//   wr_gnt       out  2      write grant; the write commits on the cycle wr_gnt is high
//   rd_req       in   2      read request, one bit per requester
//   rd_addr0/1   in   AW     read address, requester 0/1
//   rd_gnt       out  2      read grant; the address is accepted this cycle
//   rd_valid     out  2      one-hot; rd_data belongs to this requester
//   rd_data      out  DW     shared read-data bus
//   clr_start    in   1      pulse: zero-fill all 2**AW entries
//   busy         out  1      high while a clear is in progress
//   clr_done     out  1      1-cycle pulse after the last clear write
//   mem_cea      out  1      RAM port A clock enable (write)
//   mem_ada      out  AW     RAM port A address
//   mem_din      out  DW     RAM port A data
//   mem_ceb      out  1      RAM port B clock enable (read)
//   mem_adb      out  AW     RAM port B address
//   mem_dout     in   DW     RAM read data, valid 1 cycle after mem_ceb
//   mem_oce, mem_reseta, mem_resetb  out 1  driven constant 1, 0, 0
// BEHAVIOUR
//   Reset values: wr_gnt=0, rd_gnt=0, rd_valid=0, busy=0, clr_done=0,
//   both round-robin pointers favour requester 0, clear counter=0.
//   Grants:
//   - Grants are combinational from req in the same cycle.
//   - At most one write grant and one read grant per cycle.
//   - wr_gnt[i] implies req[i]; a granted requester may drop or change req
//     on the next cycle.
//   Round-robin:
//   - A lone requester is always granted.
//   - When both request, the requester not granted last time wins.
//   - The pointer updates only on an actual grant.
//   Write path:
//   - mem_cea=|wr_gnt.
//   - mem_ada/mem_din are muxed from the granted requester; they are
//     don't-care when mem_cea=0.
//   Read path:
//   - mem_ceb=|rd_gnt; mem_adb is muxed from the granted requester.
//   - rd_valid is rd_gnt registered by one cycle.
//   - rd_data=mem_dout, passed through combinationally.
//   - Back-to-back reads give 1 read/cycle throughput.
//   Collision:
//   - If the winning read address equals the granted write address in the
//     same cycle, the read grant is withheld (rd_gnt=0) and the read pointer
//     does not update.
//   - The read is granted the next cycle and returns the newly written data.
//   - No forwarding path exists.
//   Clear FSM (IDLE, CLEAR, DONE):
//   - IDLE: clr_start=1 moves to CLEAR. Grants issued in that same cycle
//     stand.
//   - CLEAR: busy=1, wr_gnt=0, rd_gnt=0. mem_cea=1, mem_ada=cnt, mem_din=0.
//     cnt increments each cycle. After cnt=2**AW-1 is written, cnt wraps to 0
//     and the FSM moves to DONE.
//   - DONE: clr_done=1 and busy=0 for one cycle, then IDLE. Grants resume in
//     DONE.
//   - Clear duration: 2**AW cycles with busy high.
//   - clr_start while busy or in DONE is ignored.
//   - Reads already in flight when CLEAR begins still return rd_valid on the
//     following cycle.
//   - rst_n low mid-clear aborts immediately: no clr_done, cnt=0, partially
//     cleared contents left as-is.
//   Arithmetic: cnt is AW+1 bits; terminal detect is cnt[AW-1:0] all-ones
//   while in CLEAR.
// STRUCTURE
//   Shared package polymem_pkg:
//   - KYBER_N=256, COEF_W=24, POLY_AW=8.
//   - Requester index constants REQ_NTT=0, REQ_SMP=1.
//   - Clear-state enum {CLR_IDLE, CLR_RUN, CLR_DONE}.
//   Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], hold,
//   gnt[1:0], pointer flop). It is instantiated twice, once for writes and
//   once for reads; the read instance's hold is driven by the collision
//   condition.
//   The RAM macro is instantiated outside this block.
// TESTING
//   1 Reset release, no requests -> all grants, rd_valid, busy, mem_cea and
//     mem_ceb read 0.
//   2 Requester 0 writes addr 0x05 data 0xABCDEF, then reads 0x05 ->
//     rd_valid=2'b01 one cycle after rd_gnt, rd_data=0xABCDEF.
//   3 Both requesters hold wr_req for 4 cycles -> wr_gnt sequence 01,10,01,10.
//     The same pattern holds for rd_req.
//   4 Same cycle: requester 0 writes 0x10 with 0x000123 and requester 1 reads
//     0x10 -> rd_gnt=0 that cycle; granted the next cycle; data 0x000123 is
//     returned.
//   5 Fill all 256 entries with nonzero data, pulse clr_start -> busy high for
//     exactly 256 cycles and wr_req is ignored. clr_done pulses once. A full
//     readback returns 0 everywhere.
//   6 Assert rst_n=0 at clear cycle 100 -> busy=0 immediately, no clr_done.
//     A new clr_start restarts from address 0.

Source files
------------

// File: rtl/polymem_pkg.sv
// Shared constants and types for the polynomial coefficient memory arbiter.
package polymem_pkg;

    localparam int unsigned KYBER_N = 256;
    localparam int unsigned COEF_W  = 24;
    localparam int unsigned POLY_AW = 8;

    // Requester indices into the request/grant vectors
    localparam int unsigned REQ_NTT = 0;
    localparam int unsigned REQ_SMP = 1;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DONE
    } clr_state_e;

endpackage

// File: rtl/polymem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. win_o is the pre-hold winner (usable for
// address muxing); gnt_o is the actual grant. The pointer moves only on a
// real grant.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       hold_i,
    output logic [1:0] win_o,
    output logic [1:0] gnt_o
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic prio_q;

    // Pick the winner; only a tie consults the pointer
    always_comb begin
        win_o = req_i;
        if (req_i == 2'b11) begin
            win_o = prio_q ? 2'b10 : 2'b01;
        end
        gnt_o = hold_i ? 2'b00 : win_o;
    end

    // Favour the other requester after each real grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (|gnt_o) begin
            prio_q <= gnt_o[0];
        end
    end

endmodule

// File: rtl/polymem_arbiter.sv
// Arbitrates one simple-dual-port coefficient RAM between the NTT core and the
// sampler/packer, with a built-in zero-fill sequencer.
module polymem_arbiter
    import polymem_pkg::*;
#(
    parameter int unsigned AW = POLY_AW,
    parameter int unsigned DW = COEF_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    wr_req_i,
    input  logic [AW-1:0] wr_addr0_i,
    input  logic [AW-1:0] wr_addr1_i,
    input  logic [DW-1:0] wr_data0_i,
    input  logic [DW-1:0] wr_data1_i,
    output logic [1:0]    wr_gnt_o,
    input  logic [1:0]    rd_req_i,
    input  logic [AW-1:0] rd_addr0_i,
    input  logic [AW-1:0] rd_addr1_i,
    output logic [1:0]    rd_gnt_o,
    output logic [1:0]    rd_valid_o,
    output logic [DW-1:0] rd_data_o,
    input  logic          clr_start_i,
    output logic          busy_o,
    output logic          clr_done_o,
    output logic          mem_cea_o,
    output logic [AW-1:0] mem_ada_o,
    output logic [DW-1:0] mem_din_o,
    output logic          mem_ceb_o,
    output logic [AW-1:0] mem_adb_o,
    input  logic [DW-1:0] mem_dout_i,
    output logic          mem_oce_o,
    output logic          mem_reseta_o,
    output logic          mem_resetb_o
);

    clr_state_e    state_q;
    logic [AW:0]   cnt_q;
    logic          busy_q;
    logic          clr_done_q;
    logic [1:0]    rd_valid_q;

    logic          clearing;
    logic          collision;
    logic [1:0]    wr_win;
    logic [1:0]    rd_win;
    logic [AW-1:0] wr_addr_sel;
    logic [DW-1:0] wr_data_sel;
    logic [AW-1:0] rd_addr_sel;

    assign clearing = (state_q == CLR_RUN);

    rr_arb2 u_wr_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (wr_req_i),
        .hold_i (clearing),
        .win_o  (wr_win),
        .gnt_o  (wr_gnt_o)
    );

    // Read is held off on a same-address write so it sees the new data next cycle
    rr_arb2 u_rd_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (rd_req_i),
        .hold_i (clearing | collision),
        .win_o  (rd_win),
        .gnt_o  (rd_gnt_o)
    );

    // Port muxing and collision detect
    always_comb begin
        wr_addr_sel = wr_win[REQ_SMP] ? wr_addr1_i : wr_addr0_i;
        wr_data_sel = wr_win[REQ_SMP] ? wr_data1_i : wr_data0_i;
        rd_addr_sel = rd_win[REQ_SMP] ? rd_addr1_i : rd_addr0_i;
        collision   = (|rd_win) && (|wr_gnt_o) && (rd_addr_sel == wr_addr_sel);

        mem_cea_o   = clearing | (|wr_gnt_o);
        mem_ada_o   = clearing ? cnt_q[AW-1:0] : wr_addr_sel;
        mem_din_o   = clearing ? '0 : wr_data_sel;
        mem_ceb_o   = |rd_gnt_o;
        mem_adb_o   = rd_addr_sel;
    end

    assign rd_data_o    = mem_dout_i;
    assign rd_valid_o   = rd_valid_q;
    assign busy_o       = busy_q;
    assign clr_done_o   = clr_done_q;
    assign mem_oce_o    = 1'b1;
    assign mem_reseta_o = 1'b0;
    assign mem_resetb_o = 1'b0;

    // Track the one-cycle RAM read latency
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 2'b00;
        end else begin
            rd_valid_q <= rd_gnt_o;
        end
    end

    // Clear sequencer: walk every address once, then pulse done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CLR_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_start_i) begin
                        state_q <= CLR_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    if (&cnt_q[AW-1:0]) begin
                        cnt_q      <= '0;
                        state_q    <= CLR_DONE;
                        busy_q     <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + {{AW{1'b0}}, 1'b1};
                    end
                end
                CLR_DONE: begin
                    clr_done_q <= 1'b0;
                    state_q    <= CLR_IDLE;
                end
                default: begin
                    state_q <= CLR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polymem_arbiter.sv
// Self-checking bench for polymem_arbiter with a behavioural RAM and a
// read-data scoreboard.
module tb_polymem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    wr_req = '0;
    logic [AW-1:0] wr_addr0 = '0, wr_addr1 = '0;
    logic [DW-1:0] wr_data0 = '0, wr_data1 = '0;
    logic [1:0]    wr_gnt;
    logic [1:0]    rd_req = '0;
    logic [AW-1:0] rd_addr0 = '0, rd_addr1 = '0;
    logic [1:0]    rd_gnt, rd_valid;
    logic [DW-1:0] rd_data;
    logic          clr_start = 1'b0;
    logic          busy, clr_done;
    logic          mem_cea, mem_ceb, mem_oce, mem_reseta, mem_resetb;
    logic [AW-1:0] mem_ada, mem_adb;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW:0]   exp_q   [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    polymem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_req_i     (wr_req),
        .wr_addr0_i   (wr_addr0),
        .wr_addr1_i   (wr_addr1),
        .wr_data0_i   (wr_data0),
        .wr_data1_i   (wr_data1),
        .wr_gnt_o     (wr_gnt),
        .rd_req_i     (rd_req),
        .rd_addr0_i   (rd_addr0),
        .rd_addr1_i   (rd_addr1),
        .rd_gnt_o     (rd_gnt),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .clr_start_i  (clr_start),
        .busy_o       (busy),
        .clr_done_o   (clr_done),
        .mem_cea_o    (mem_cea),
        .mem_ada_o    (mem_ada),
        .mem_din_o    (mem_din),
        .mem_ceb_o    (mem_ceb),
        .mem_adb_o    (mem_adb),
        .mem_dout_i   (mem_dout),
        .mem_oce_o    (mem_oce),
        .mem_reseta_o (mem_reseta),
        .mem_resetb_o (mem_resetb)
    );

    // Behavioural simple-dual-port RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_cea) ram[mem_ada] <= mem_din;
        if (mem_ceb) mem_dout <= ram[mem_adb];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int who);
        return (who == 1) ? 2'b10 : 2'b01;
    endfunction

    // Scoreboard: every returned read must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && rd_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                check_eq("rd_unexpected", {30'd0, rd_valid}, 32'd0);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check_eq("rd_valid_who", {30'd0, rd_valid}, {30'd0, onehot(int'(e[DW]))});
                check_eq("rd_data", {8'd0, rd_data}, {8'd0, e[DW-1:0]});
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        wr_req = '0;
        rd_req = '0;
        clr_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_write(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who == 0) begin
            wr_addr0 = a; wr_data0 = d;
        end else begin
            wr_addr1 = a; wr_data1 = d;
        end
        wr_req = onehot(who);
        @(negedge clk);
        check_eq("wr_gnt", {30'd0, wr_gnt}, {30'd0, onehot(who)});
        check_eq("mem_ada", {24'd0, mem_ada}, {24'd0, a});
        check_eq("mem_din", {8'd0, mem_din}, {8'd0, d});
        ref_mem[a] = d;
        @(posedge clk);
        #1 wr_req = '0;
    endtask

    task automatic do_read(input int who, input logic [AW-1:0] a);
        if (who == 0) rd_addr0 = a;
        else rd_addr1 = a;
        rd_req = onehot(who);
        @(negedge clk);
        check_eq("rd_gnt", {30'd0, rd_gnt}, {30'd0, onehot(who)});
        check_eq("mem_adb", {24'd0, mem_adb}, {24'd0, a});
        exp_q.push_back({(who == 1), ref_mem[a]});
        @(posedge clk);
        #1 rd_req = '0;
    endtask

    // Run a full clear while hammering both write requests for the first 200 busy cycles
    task automatic run_clear(input string tag);
        int busy_cnt, done_cnt, bad, guard;
        busy_cnt = 0; done_cnt = 0; bad = 0; guard = 0;
        wr_addr0 = 8'h33; wr_data0 = 24'h111111;
        wr_addr1 = 8'h44; wr_data1 = 24'h222222;
        clr_start = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
        wr_req = 2'b11;
        while (done_cnt == 0 && guard < 600) begin
            @(negedge clk);
            guard++;
            if (busy) begin
                if (busy_cnt == 0) check_eq({tag, "_first_ada"}, {24'd0, mem_ada}, 32'd0);
                busy_cnt++;
                if (wr_gnt != 2'b00 || rd_gnt != 2'b00 || !mem_cea || mem_din != '0) bad++;
            end
            if (clr_done) done_cnt++;
            @(posedge clk);
            #1;
            if (busy_cnt >= 200) wr_req = '0;
        end
        wr_req = '0;
        @(negedge clk);
        if (clr_done) done_cnt++;
        check_eq({tag, "_busy_cycles"}, busy_cnt, 32'd256);
        check_eq({tag, "_done_pulses"}, done_cnt, 32'd1);
        check_eq({tag, "_grant_in_clear"}, bad, 32'd0);
        check_eq({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq [4];
        int busy_cnt, guard, done_seen;
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;

        // 1: reset state
        apply_reset();
        @(negedge clk);
        check_eq("rst_wr_gnt", {30'd0, wr_gnt}, 32'd0);
        check_eq("rst_rd_gnt", {30'd0, rd_gnt}, 32'd0);
        check_eq("rst_rd_valid", {30'd0, rd_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_clr_done", {31'd0, clr_done}, 32'd0);
        check_eq("rst_cea_ceb", {30'd0, mem_cea, mem_ceb}, 32'd0);
        check_eq("rst_static", {29'd0, mem_oce, mem_reseta, mem_resetb}, 32'd4);
        @(posedge clk);
        #1;

        // 2: simple write then read, valid exactly one cycle after grant
        do_write(0, 8'h05, 24'hABCDEF);
        do_read(0, 8'h05);
        @(negedge clk);
        check_eq("t2_rd_valid", {30'd0, rd_valid}, 32'd1);
        @(posedge clk);
        #1;

        // 3: round-robin alternation from a fresh reset
        apply_reset();
        wr_addr0 = 8'h30; wr_data0 = 24'h0A0A0A;
        wr_addr1 = 8'h31; wr_data1 = 24'h0B0B0B;
        wr_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t3_wr_seq", {30'd0, wr_gnt}, {30'd0, seq[i]});
            if (seq[i] == 2'b01) ref_mem[8'h30] = 24'h0A0A0A;
            else ref_mem[8'h31] = 24'h0B0B0B;
            @(posedge clk);
            #1;
        end
        wr_req = '0;
        rd_addr0 = 8'h30;
        rd_addr1 = 8'h31;
        rd_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t3_rd_seq", {30'd0, rd_gnt}, {30'd0, seq[i]});
            if (seq[i] == 2'b01) exp_q.push_back({1'b0, ref_mem[8'h30]});
            else exp_q.push_back({1'b1, ref_mem[8'h31]});
            @(posedge clk);
            #1;
        end
        rd_req = '0;

        // 4: same-address write/read collision
        wr_addr0 = 8'h10; wr_data0 = 24'h000123; wr_req = 2'b01;
        rd_addr1 = 8'h10; rd_req = 2'b10;
        @(negedge clk);
        check_eq("t4_wr_gnt", {30'd0, wr_gnt}, 32'd1);
        check_eq("t4_rd_held", {30'd0, rd_gnt}, 32'd0);
        ref_mem[8'h10] = 24'h000123;
        @(posedge clk);
        #1 wr_req = '0;
        @(negedge clk);
        check_eq("t4_rd_gnt", {30'd0, rd_gnt}, 32'd2);
        exp_q.push_back({1'b1, ref_mem[8'h10]});
        @(posedge clk);
        #1 rd_req = '0;

        // 5: fill, clear, read everything back as zero
        for (int i = 0; i < 256; i++) do_write(i % 2, 8'(i), 24'(i * 3 + 1));
        run_clear("t5");
        for (int i = 0; i < 256; i++) do_read(i % 2, 8'(i));
        @(posedge clk);
        #1;

        // 6: reset in the middle of a clear
        do_write(1, 8'd10, 24'h000077);
        do_write(0, 8'd200, 24'h000055);
        clr_start = 1'b1;
        @(posedge clk);
        #1 clr_start = 1'b0;
        busy_cnt = 0; guard = 0;
        while (busy_cnt < 100 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (busy) busy_cnt++;
        end
        check_eq("t6_reached_100", busy_cnt, 32'd100);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_busy_abort", {31'd0, busy}, 32'd0);
        check_eq("t6_done_abort", {31'd0, clr_done}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (clr_done || busy) done_seen++;
        end
        check_eq("t6_no_done", done_seen, 32'd0);
        @(posedge clk);
        #1;
        ref_mem[10] = '0;
        do_read(0, 8'd10);
        do_read(1, 8'd200);
        run_clear("t6");
        do_read(1, 8'd200);
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
